instruction_loader: RTL and testbench
=====================================

Name: instruction_loader

Overview:
Upstream feeder of the `_if` stage. It assembles program bytes received from the debug/UART link into 32-bit instruction words, then writes each word into the IF instruction memory with a one-cycle `o_write_mem` pulse. Loading ends when the halt word (all ones) has been written, or aborts if IF reports memory full. Its outputs connect directly to the `_if` ports `i_instruction`, `i_write_mem` and `o_full_mem`.

Parameters:
INSTRUCTION_SIZE, 32, instruction word width in bits (`ARQUITECTURE_BITS`)
BYTE_SIZE, 8, width of one received byte
MEM_SIZE_IN_WORDS, 20, IF instruction memory depth; sets the word counter range
HALT_INSTRUCTION, 32'hFFFFFFFF, end-of-program marker word

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_load_start  in  1  one-cycle pulse; starts or restarts a load
i_rx_data  in  BYTE_SIZE  received byte
i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid this cycle
i_full_mem  in  1  IF memory full (from `_if` o_full_mem)
o_instruction  out  INSTRUCTION_SIZE  assembled word, to `_if` i_instruction
o_write_mem  out  1  write strobe, to `_if` i_write_mem
o_busy  out  1  high in RECV or WRITE
o_load_done  out  1  halt word written; sticky
o_error  out  1  write attempted while memory full; sticky
o_word_count  out  $clog2(MEM_SIZE_IN_WORDS)+1  number of words written in the current load

Behaviour:
- Reset (synchronous, i_reset=1 at a rising edge):
  - state=IDLE, byte index=0.
  - o_instruction=0, o_write_mem=0, o_busy=0, o_load_done=0, o_error=0, o_word_count=0.
  - Reset wins over every other input in the same cycle and aborts any load in progress.
- States: IDLE, RECV, WRITE, DONE, ERROR.
- IDLE:
  - i_rx_valid is ignored.
  - i_load_start -> RECV, byte index=0, o_word_count=0.
- RECV:
  - Each i_rx_valid shifts the byte in MSB-first: the first byte lands in bits [31:24], the fourth in [7:0].
  - On the 4th byte -> WRITE on the next edge; the assembled word is registered on o_instruction.
- WRITE (exactly one cycle):
  - If i_full_mem=0: o_write_mem=1, o_word_count+1. Next state is DONE if the word equals HALT_INSTRUCTION, else RECV with byte index=0.
  - If i_full_mem=1: no write (o_write_mem=0), next state ERROR.
  - o_instruction is held stable throughout WRITE and stays unchanged until the next word completes.
- Back-to-back byte: i_rx_valid during WRITE is accepted as byte 0 of the next word (next state RECV, index=1). It is dropped if the next state is DONE or ERROR.
- Write latency: o_write_mem asserts 1 cycle after the edge that captured the 4th byte.
- DONE: o_load_done=1, o_busy=0; i_rx_valid ignored.
- ERROR: o_error=1, o_busy=0; i_rx_valid ignored.
- i_load_start in any state:
  - Restarts: -> RECV, byte index=0, o_word_count=0, o_load_done=0, o_error=0.
  - Any partial word is discarded.
  - In WRITE, the restart has priority and the pending write is suppressed.
- The loader never clears IF memory; a restart relies on the IF stage's own reset.
- i_load_start and i_rx_valid in the same cycle: the restart applies and the byte is discarded.
- o_word_count saturates at MEM_SIZE_IN_WORDS; i_full_mem is the authoritative full indication.

Decomposition:
- Shared header (alongside `tb.vh` defines): state encodings (3 bits), HALT_INSTRUCTION, BYTE_SIZE, `ARQUITECTURE_BITS`.
- One sub-module, `word_assembler`: a MSB-first byte shift register plus a 2-bit index, with clear and shift inputs and word/complete outputs. The FSM, write strobe and counters stay in instruction_loader.

Test Plan:
1. Reset held for a random 1–20 ticks, then released -> all outputs 0, state IDLE; 10 bytes with i_rx_valid in IDLE produce no o_write_mem.
2. i_load_start, then bytes 12,34,56,78 then FF,FF,FF,FF, spaced 3 ticks apart -> write pulses carrying 32'h12345678 then 32'hFFFFFFFF; o_word_count=2; o_load_done=1 one cycle after the second write; o_busy=0.
3. 10 random words plus the halt word sent with back-to-back i_rx_valid, including a byte during each WRITE cycle -> 11 writes whose data matches the sent words in order, no byte lost, o_word_count=11.
4. i_full_mem forced to 1 before the 4th byte of word 3 -> no write for word 3, o_error=1, o_word_count=2; later bytes ignored.
5. i_load_start after 2 bytes of a word -> partial word discarded; the next 4 bytes AA,BB,CC,DD produce 32'hAABBCCDD and o_word_count=1.
6. i_reset asserted in the WRITE cycle -> o_write_mem=0 that cycle, all outputs 0 at the next edge; i_load_start together with i_rx_valid -> restart wins and the byte is dropped.

Source files
------------

// File: rtl/instruction_loader_pkg.sv
// Shared constants and FSM encoding for the program loader feeding the IF stage.
// Bytes arrive MSB-first; the all-ones word marks the end of the program.
package instruction_loader_pkg;

    localparam int ARQUITECTURE_BITS = 32;
    localparam int BYTE_SIZE         = 8;
    localparam int MEM_SIZE_IN_WORDS = 20;

    localparam logic [ARQUITECTURE_BITS-1:0] HALT_INSTRUCTION = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } loader_state_t;

    function automatic logic is_busy_state(input loader_state_t st);
        return (st == ST_RECV) || (st == ST_WRITE);
    endfunction

endpackage

// File: rtl/instruction_loader_word_assembler.sv
// MSB-first byte shift register; o_word/o_complete are the word as it would look
// with the current byte included, so the parent can register it on the 4th byte.
module word_assembler #(
    parameter int BYTE_SIZE = instruction_loader_pkg::BYTE_SIZE,
    parameter int WORD_SIZE = instruction_loader_pkg::ARQUITECTURE_BITS
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_clear,
    input  logic                 i_shift,
    input  logic [BYTE_SIZE-1:0] i_byte,
    output logic [WORD_SIZE-1:0] o_word,
    output logic                 o_complete
);
    import instruction_loader_pkg::*;

    logic [WORD_SIZE-1:0] r_word;
    logic [1:0]           r_index;

    // Clear wins over shift: a restart discards whatever byte arrives with it.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_word  <= '0;
            r_index <= 2'd0;
        end else if (i_shift) begin
            r_word  <= {r_word[WORD_SIZE-BYTE_SIZE-1:0], i_byte};
            r_index <= r_index + 2'd1;
        end
    end

    assign o_word     = {r_word[WORD_SIZE-BYTE_SIZE-1:0], i_byte};
    assign o_complete = i_shift && !i_clear && (r_index == 2'd3);

endmodule

// File: rtl/instruction_loader.sv
// Assembles UART bytes into 32-bit words and writes them into IF memory, one
// o_write_mem pulse in the cycle after the 4th byte; stops on the halt word or memory full.
module instruction_loader #(
    parameter int                              INSTRUCTION_SIZE  = instruction_loader_pkg::ARQUITECTURE_BITS,
    parameter int                              BYTE_SIZE         = instruction_loader_pkg::BYTE_SIZE,
    parameter int                              MEM_SIZE_IN_WORDS = instruction_loader_pkg::MEM_SIZE_IN_WORDS,
    parameter logic [INSTRUCTION_SIZE-1:0]     HALT_INSTRUCTION  = instruction_loader_pkg::HALT_INSTRUCTION
) (
    input  logic                                   i_clk,
    input  logic                                   i_reset,
    input  logic                                   i_load_start,
    input  logic [BYTE_SIZE-1:0]                   i_rx_data,
    input  logic                                   i_rx_valid,
    input  logic                                   i_full_mem,
    output logic [INSTRUCTION_SIZE-1:0]            o_instruction,
    output logic                                   o_write_mem,
    output logic                                   o_busy,
    output logic                                   o_load_done,
    output logic                                   o_error,
    output logic [$clog2(MEM_SIZE_IN_WORDS):0]     o_word_count
);
    import instruction_loader_pkg::*;

    localparam int CNT_W = $clog2(MEM_SIZE_IN_WORDS) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_SIZE_IN_WORDS);

    loader_state_t                r_state;
    logic [INSTRUCTION_SIZE-1:0]  r_instruction;
    logic                         r_busy;
    logic                         r_load_done;
    logic                         r_error;
    logic [CNT_W-1:0]             r_word_count;

    logic                         w_in_write;
    logic                         w_is_halt;
    logic                         w_write;
    logic                         w_shift;
    logic                         w_complete;
    logic [INSTRUCTION_SIZE-1:0]  w_word;

    assign w_in_write = (r_state == ST_WRITE);
    assign w_is_halt  = (r_instruction == HALT_INSTRUCTION);

    // The strobe is decided inside the WRITE cycle so that reset, restart and
    // a late full indication can all still cancel it before IF samples it.
    assign w_write = w_in_write && !i_full_mem && !i_load_start && !i_reset;

    // A byte during WRITE starts the next word only if loading continues.
    assign w_shift = i_rx_valid && !i_load_start &&
                     ((r_state == ST_RECV) || (w_write && !w_is_halt));

    word_assembler #(
        .BYTE_SIZE (BYTE_SIZE),
        .WORD_SIZE (INSTRUCTION_SIZE)
    ) u_word_assembler (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clear    (i_load_start),
        .i_shift    (w_shift),
        .i_byte     (i_rx_data),
        .o_word     (w_word),
        .o_complete (w_complete)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_instruction <= '0;
            r_busy        <= 1'b0;
            r_load_done   <= 1'b0;
            r_error       <= 1'b0;
            r_word_count  <= '0;
        end else if (i_load_start) begin
            r_state      <= ST_RECV;
            r_busy       <= 1'b1;
            r_load_done  <= 1'b0;
            r_error      <= 1'b0;
            r_word_count <= '0;
        end else begin
            case (r_state)
                ST_RECV: begin
                    if (w_complete) begin
                        r_state       <= ST_WRITE;
                        r_instruction <= w_word;
                    end
                end
                ST_WRITE: begin
                    if (i_full_mem) begin
                        r_state <= ST_ERROR;
                        r_busy  <= 1'b0;
                        r_error <= 1'b1;
                    end else begin
                        if (r_word_count < CNT_MAX) begin
                            r_word_count <= r_word_count + 1'b1;
                        end
                        if (w_is_halt) begin
                            r_state     <= ST_DONE;
                            r_busy      <= 1'b0;
                            r_load_done <= 1'b1;
                        end else begin
                            r_state <= ST_RECV;
                            r_busy  <= is_busy_state(ST_RECV);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_instruction = r_instruction;
    assign o_write_mem   = w_write;
    assign o_busy        = r_busy;
    assign o_load_done   = r_load_done;
    assign o_error       = r_error;
    assign o_word_count  = r_word_count;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: inputs change and outputs are sampled
// 1ns after each rising edge; a negedge monitor records every write pulse.
module tb_instruction_loader;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_load_start = 1'b0;
    logic [7:0]  i_rx_data = 8'h00;
    logic        i_rx_valid = 1'b0;
    logic        i_full_mem = 1'b0;
    logic [31:0] o_instruction;
    logic        o_write_mem;
    logic        o_busy;
    logic        o_load_done;
    logic        o_error;
    logic [5:0]  o_word_count;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] wr_q[$];

    instruction_loader dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_load_start  (i_load_start),
        .i_rx_data     (i_rx_data),
        .i_rx_valid    (i_rx_valid),
        .i_full_mem    (i_full_mem),
        .o_instruction (o_instruction),
        .o_write_mem   (o_write_mem),
        .o_busy        (o_busy),
        .o_load_done   (o_load_done),
        .o_error       (o_error),
        .o_word_count  (o_word_count)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (o_write_mem === 1'b1) wr_q.push_back(o_instruction);
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        tick();
        i_rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        i_load_start = 1'b1;
        tick();
        i_load_start = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        n = $urandom_range(1, 20);
        i_reset = 1'b1;
        idle(n);
        i_reset = 1'b0;
        tick();
        n_checks++; if (o_instruction !== 32'h0) $display("FAIL reset_instr: got %h want 0", o_instruction); else n_pass++;
        n_checks++; if (o_write_mem !== 1'b0) $display("FAIL reset_write: got %b want 0", o_write_mem); else n_pass++;
        n_checks++; if (o_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", o_busy); else n_pass++;
        n_checks++; if (o_load_done !== 1'b0) $display("FAIL reset_done: got %b want 0", o_load_done); else n_pass++;
        n_checks++; if (o_error !== 1'b0) $display("FAIL reset_error: got %b want 0", o_error); else n_pass++;
        n_checks++; if (o_word_count !== 6'd0) $display("FAIL reset_count: got %0d want 0", o_word_count); else n_pass++;
        wr_q.delete();
        for (int i = 0; i < 10; i++) send_byte(8'(8'h30 + i));
        idle(2);
        n_checks++; if (wr_q.size() != 0) $display("FAIL idle_bytes_writes: got %0d want 0", wr_q.size()); else n_pass++;
        n_checks++; if (o_busy !== 1'b0) $display("FAIL idle_bytes_busy: got %b want 0", o_busy); else n_pass++;
    endtask

    task automatic test_basic_load();
        logic [7:0] bytes [8];
        bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        wr_q.delete();
        pulse_start();
        n_checks++; if (o_busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", o_busy); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            send_byte(bytes[i]);
            if (i == 2) begin
                n_checks++; if (o_write_mem !== 1'b0) $display("FAIL basic_early_write: got %b want 0", o_write_mem); else n_pass++;
            end
            if (i == 3) begin
                n_checks++; if (o_write_mem !== 1'b1) $display("FAIL basic_latency: got %b want 1", o_write_mem); else n_pass++;
                n_checks++; if (o_instruction !== 32'h12345678) $display("FAIL basic_word1: got %h want 12345678", o_instruction); else n_pass++;
            end
            if (i == 7) begin
                n_checks++; if (o_load_done !== 1'b0) $display("FAIL basic_done_early: got %b want 0", o_load_done); else n_pass++;
                tick();
                n_checks++; if (o_load_done !== 1'b1) $display("FAIL basic_done: got %b want 1", o_load_done); else n_pass++;
            end else begin
                idle(2);
            end
        end
        n_checks++; if (o_busy !== 1'b0) $display("FAIL basic_busy_end: got %b want 0", o_busy); else n_pass++;
        n_checks++; if (o_word_count !== 6'd2) $display("FAIL basic_count: got %0d want 2", o_word_count); else n_pass++;
        n_checks++; if (wr_q.size() != 2) $display("FAIL basic_nwrites: got %0d want 2", wr_q.size()); else n_pass++;
        if (wr_q.size() == 2) begin
            n_checks++; if (wr_q[0] !== 32'h12345678) $display("FAIL basic_wr0: got %h want 12345678", wr_q[0]); else n_pass++;
            n_checks++; if (wr_q[1] !== 32'hFFFFFFFF) $display("FAIL basic_wr1: got %h want ffffffff", wr_q[1]); else n_pass++;
        end
        send_byte(8'h55);
        n_checks++; if (o_word_count !== 6'd2) $display("FAIL basic_done_ignores: got %0d want 2", o_word_count); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [11];
        logic [31:0] cur;
        words = '{32'hDEADBEEF, 32'h00000000, 32'hCAFEF00D, 32'h0BADF00D, 32'h13579BDF,
                  32'h2468ACE0, 32'hFFFFFF00, 32'h00FFFFFF, 32'h80000001, 32'h7FFFFFFE,
                  32'hFFFFFFFF};
        wr_q.delete();
        pulse_start();
        n_checks++; if (o_load_done !== 1'b0) $display("FAIL b2b_done_cleared: got %b want 0", o_load_done); else n_pass++;
        for (int w = 0; w < 11; w++) begin
            cur = words[w];
            for (int b = 0; b < 4; b++) begin
                i_rx_valid = 1'b1;
                i_rx_data  = cur[31-8*b -: 8];
                tick();
            end
        end
        i_rx_valid = 1'b0;
        n_checks++; if (o_write_mem !== 1'b1) $display("FAIL b2b_last_write: got %b want 1", o_write_mem); else n_pass++;
        tick();
        n_checks++; if (wr_q.size() != 11) $display("FAIL b2b_nwrites: got %0d want 11", wr_q.size()); else n_pass++;
        for (int w = 0; w < 11 && w < wr_q.size(); w++) begin
            n_checks++; if (wr_q[w] !== words[w]) $display("FAIL b2b_word%0d: got %h want %h", w, wr_q[w], words[w]); else n_pass++;
        end
        n_checks++; if (o_word_count !== 6'd11) $display("FAIL b2b_count: got %0d want 11", o_word_count); else n_pass++;
        n_checks++; if (o_load_done !== 1'b1) $display("FAIL b2b_done: got %b want 1", o_load_done); else n_pass++;
    endtask

    task automatic test_mem_full();
        logic [7:0] bytes [12];
        bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
        wr_q.delete();
        pulse_start();
        for (int i = 0; i < 12; i++) begin
            if (i == 11) i_full_mem = 1'b1;
            send_byte(bytes[i]);
            if (i == 11) begin
                n_checks++; if (o_write_mem !== 1'b0) $display("FAIL full_no_strobe: got %b want 0", o_write_mem); else n_pass++;
            end
            idle(1);
        end
        n_checks++; if (o_error !== 1'b1) $display("FAIL full_error: got %b want 1", o_error); else n_pass++;
        n_checks++; if (o_busy !== 1'b0) $display("FAIL full_busy: got %b want 0", o_busy); else n_pass++;
        i_full_mem = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(8'hE0);
        idle(2);
        n_checks++; if (o_word_count !== 6'd2) $display("FAIL full_count: got %0d want 2", o_word_count); else n_pass++;
        n_checks++; if (wr_q.size() != 2) $display("FAIL full_nwrites: got %0d want 2", wr_q.size()); else n_pass++;
        n_checks++; if (o_error !== 1'b1) $display("FAIL full_sticky: got %b want 1", o_error); else n_pass++;
    endtask

    task automatic test_restart_partial();
        logic [7:0] bytes [4];
        bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        wr_q.delete();
        pulse_start();
        n_checks++; if (o_error !== 1'b0) $display("FAIL restart_error_cleared: got %b want 0", o_error); else n_pass++;
        send_byte(8'h11);
        send_byte(8'h22);
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            send_byte(bytes[i]);
            if (i == 3) begin
                n_checks++; if (o_instruction !== 32'hAABBCCDD) $display("FAIL restart_word: got %h want aabbccdd", o_instruction); else n_pass++;
            end
            idle(1);
        end
        n_checks++; if (o_word_count !== 6'd1) $display("FAIL restart_count: got %0d want 1", o_word_count); else n_pass++;
        n_checks++; if (wr_q.size() != 1) $display("FAIL restart_nwrites: got %0d want 1", wr_q.size()); else n_pass++;
    endtask

    task automatic test_reset_in_write();
        wr_q.delete();
        pulse_start();
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        i_reset = 1'b1;
        #1;
        n_checks++; if (o_write_mem !== 1'b0) $display("FAIL rstw_strobe: got %b want 0", o_write_mem); else n_pass++;
        tick();
        i_reset = 1'b0;
        n_checks++; if (o_instruction !== 32'h0) $display("FAIL rstw_instr: got %h want 0", o_instruction); else n_pass++;
        n_checks++; if (o_word_count !== 6'd0) $display("FAIL rstw_count: got %0d want 0", o_word_count); else n_pass++;
        n_checks++; if (o_busy !== 1'b0) $display("FAIL rstw_busy: got %b want 0", o_busy); else n_pass++;
        n_checks++; if (wr_q.size() != 0) $display("FAIL rstw_nwrites: got %0d want 0", wr_q.size()); else n_pass++;
        i_load_start = 1'b1;
        i_rx_valid   = 1'b1;
        i_rx_data    = 8'h99;
        tick();
        i_load_start = 1'b0;
        i_rx_valid   = 1'b0;
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        n_checks++; if (o_write_mem !== 1'b0) $display("FAIL start_byte_dropped: got %b want 0", o_write_mem); else n_pass++;
        send_byte(8'h04);
        n_checks++; if (o_instruction !== 32'h01020304) $display("FAIL start_word: got %h want 01020304", o_instruction); else n_pass++;
        n_checks++; if (o_write_mem !== 1'b1) $display("FAIL start_write: got %b want 1", o_write_mem); else n_pass++;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_back_to_back();
        test_mem_full();
        test_restart_partial();
        test_reset_in_write();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
